// File: rtl/johnson_phase_monitor.sv
// Johnson counter phase monitor: decodes the 4-bit code, tracks lock,
// flags sequence faults and counts revolutions while locked.
module johnson_phase_monitor #(
  parameter int LOCK_CNT = 3,
  parameter int REV_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       q,
  input  logic             clear_err,
  output logic [2:0]       phase,
  output logic [7:0]       phase_oh,
  output logic             code_valid,
  output logic             locked,
  output logic             fault,
  output logic [REV_W-1:0] rev_count,
  output logic             wrap_pulse
);

  typedef enum logic [1:0] {
    UNLOCKED,
    LOCKING,
    LOCKED,
    FAULT
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] run_q, run_d;
  logic       prev_vld_q;
  logic       dec_vld;
  logic [2:0] dec_ph;
  logic       adv, hold, bad, wrap;

  always_comb begin
    dec_vld = 1'b1;
    dec_ph  = 3'd0;
    unique case (q)
      4'b0000: dec_ph = 3'd0;
      4'b0001: dec_ph = 3'd1;
      4'b0011: dec_ph = 3'd2;
      4'b0111: dec_ph = 3'd3;
      4'b1111: dec_ph = 3'd4;
      4'b1110: dec_ph = 3'd5;
      4'b1100: dec_ph = 3'd6;
      4'b1000: dec_ph = 3'd7;
      default: dec_vld = 1'b0;
    endcase
  end

  // phase register doubles as the stored previous legal phase
  assign adv  = dec_vld && prev_vld_q && (dec_ph == phase + 3'd1);
  assign hold = dec_vld && prev_vld_q && (dec_ph == phase);
  assign bad  = !(adv || hold);
  assign wrap = (state_q == LOCKED) && adv && (phase == 3'd7);

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    unique case (state_q)
      UNLOCKED: begin
        if (dec_vld) begin
          state_d = LOCKING;
          run_d   = 4'd0;
        end
      end
      LOCKING: begin
        if (adv) begin
          run_d = run_q + 4'd1;
          if (run_q + 4'd1 == 4'(LOCK_CNT)) state_d = LOCKED;
        end else if (bad) begin
          state_d = UNLOCKED;
          run_d   = 4'd0;
        end
      end
      LOCKED: begin
        if (bad) state_d = FAULT;
      end
      FAULT: begin
        if (clear_err) state_d = UNLOCKED;
      end
      default: state_d = UNLOCKED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= UNLOCKED;
      run_q      <= 4'd0;
      prev_vld_q <= 1'b0;
      phase      <= 3'd0;
      phase_oh   <= 8'd0;
      code_valid <= 1'b0;
      locked     <= 1'b0;
      fault      <= 1'b0;
      rev_count  <= '0;
      wrap_pulse <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      prev_vld_q <= prev_vld_q | dec_vld;
      code_valid <= dec_vld;
      phase_oh   <= dec_vld ? (8'd1 << dec_ph) : 8'd0;
      if (dec_vld) phase <= dec_ph;
      locked     <= (state_d == LOCKED);
      fault      <= (state_d == FAULT);
      wrap_pulse <= wrap;
      if (wrap) rev_count <= rev_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Directed self-checking bench for johnson_phase_monitor.
module tb_johnson_phase_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] q;
  logic       clear_err;
  logic [2:0] phase, phase2;
  logic [7:0] phase_oh, phase_oh2;
  logic       code_valid, code_valid2;
  logic       locked, locked2;
  logic       fault, fault2;
  logic [7:0] rev_count;
  logic [1:0] rev_count2;
  logic       wrap_pulse, wrap_pulse2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  johnson_phase_monitor #(.LOCK_CNT(3), .REV_W(8)) dut (
    .clk(clk), .reset(reset), .q(q), .clear_err(clear_err),
    .phase(phase), .phase_oh(phase_oh), .code_valid(code_valid),
    .locked(locked), .fault(fault), .rev_count(rev_count),
    .wrap_pulse(wrap_pulse)
  );

  johnson_phase_monitor #(.LOCK_CNT(3), .REV_W(2)) dut2 (
    .clk(clk), .reset(reset), .q(q), .clear_err(clear_err),
    .phase(phase2), .phase_oh(phase_oh2), .code_valid(code_valid2),
    .locked(locked2), .fault(fault2), .rev_count(rev_count2),
    .wrap_pulse(wrap_pulse2)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic ce = 1'b0);
    @(negedge clk);
    q = v;
    clear_err = ce;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".phase"}, 32'(phase), 0);
    chk({tag, ".oh"}, 32'(phase_oh), 0);
    chk({tag, ".cv"}, 32'(code_valid), 0);
    chk({tag, ".locked"}, 32'(locked), 0);
    chk({tag, ".fault"}, 32'(fault), 0);
    chk({tag, ".rev"}, 32'(rev_count), 0);
    chk({tag, ".wrap"}, 32'(wrap_pulse), 0);
  endtask

  // one revolution starting after phase 3: F,E,C,8,0,1,3,7
  task automatic rev_from3();
    drive(4'hF); drive(4'hE); drive(4'hC); drive(4'h8);
    drive(4'h0); drive(4'h1); drive(4'h3); drive(4'h7);
  endtask

  initial begin
    reset = 1'b1;
    q = 4'h0;
    clear_err = 1'b0;
    drive(4'h0);
    drive(4'h0);
    chk_zero("reset");
    reset = 1'b0;

    // lock-in
    drive(4'h0); drive(4'h1); drive(4'h3);
    chk("lockin.pre", 32'(locked), 0);
    drive(4'h7);
    chk("lockin.locked", 32'(locked), 1);
    chk("lockin.phase", 32'(phase), 3);
    chk("lockin.oh", 32'(phase_oh), 32'h08);
    chk("lockin.fault", 32'(fault), 0);
    chk("lockin.rev", 32'(rev_count), 0);

    // first revolution
    drive(4'hF); drive(4'hE); drive(4'hC); drive(4'h8);
    chk("rev.prewrap", 32'(wrap_pulse), 0);
    chk("rev.oh7", 32'(phase_oh), 32'h80);
    drive(4'h0);
    chk("rev.wrap", 32'(wrap_pulse), 1);
    chk("rev.count1", 32'(rev_count), 1);
    drive(4'h1);
    chk("rev.wrapone", 32'(wrap_pulse), 0);
    chk("rev.hold1", 32'(rev_count), 1);
    for (int k = 0; k < 3; k++) begin
      drive(4'h3); drive(4'h7); drive(4'hF); drive(4'hE);
      drive(4'hC); drive(4'h8); drive(4'h0); drive(4'h1);
    end
    chk("rev.count4", 32'(rev_count), 4);
    chk("rev.w2wrap", 32'(rev_count2), 0);

    // fault while locked at phase 2
    drive(4'h3);
    chk("flt.phase2", 32'(phase), 2);
    drive(4'h5);
    chk("flt.cv", 32'(code_valid), 0);
    chk("flt.oh", 32'(phase_oh), 0);
    chk("flt.phase", 32'(phase), 2);
    chk("flt.fault", 32'(fault), 1);
    chk("flt.locked", 32'(locked), 0);
    drive(4'h7); drive(4'hF);
    chk("flt.sticky", 32'(fault), 1);
    chk("flt.phase4", 32'(phase), 4);
    drive(4'hE, 1'b1);
    chk("clr.fault", 32'(fault), 0);
    chk("clr.locked", 32'(locked), 0);
    chk("clr.phase", 32'(phase), 5);
    drive(4'hC); drive(4'h8); drive(4'h0);
    chk("relock.pre", 32'(locked), 0);
    chk("relock.nowrap", 32'(wrap_pulse), 0);
    chk("relock.rev", 32'(rev_count), 4);
    drive(4'h1);
    chk("relock.locked", 32'(locked), 1);

    // clear_err outside FAULT is ignored
    drive(4'h3, 1'b1);
    chk("ceidle.locked", 32'(locked), 1);

    // skip while LOCKING: fault, clear on illegal code, then 0,1,7
    drive(4'h5);
    drive(4'h5, 1'b1);
    chk("skip.clr", 32'(fault), 0);
    drive(4'h0); drive(4'h1); drive(4'h7);
    chk("skip.locked", 32'(locked), 0);
    chk("skip.fault", 32'(fault), 0);
    drive(4'hF); drive(4'hE); drive(4'hC);
    chk("skip.pre", 32'(locked), 0);
    drive(4'h8);
    chk("skip.locked2", 32'(locked), 1);

    // hold then lock
    reset = 1'b1;
    drive(4'h0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(4'h0);
      chk($sformatf("hold.%0d", i), 32'(locked), 0);
    end
    drive(4'h1); drive(4'h3);
    chk("hold.pre", 32'(locked), 0);
    drive(4'h7);
    chk("hold.locked", 32'(locked), 1);
    chk("hold.fault", 32'(fault), 0);

    // reset mid-operation with rev_count=5 and clear_err set
    for (int k = 0; k < 5; k++) rev_from3();
    chk("mid.rev5", 32'(rev_count), 5);
    chk("mid.w2rev", 32'(rev_count2), 1);
    reset = 1'b1;
    drive(4'hF, 1'b1);
    chk_zero("midrst");
    chk("midrst.w2rev", 32'(rev_count2), 0);
    reset = 1'b0;
    drive(4'h1);
    chk("post.phase", 32'(phase), 1);
    chk("post.locked", 32'(locked), 0);
    chk("post.fault", 32'(fault), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
